// File: rtl/q_8_34e.sv
// Sequential ones counter: shifts R1 out through flag E and counts 1-bits in R2.
// Define Q_8_34E_ONEHOT_EN for a one-hot controller state register.
module q_8_34e #(
    parameter int data_size = 8,
    parameter int r2_size   = 4
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 start,
    input  logic [data_size-1:0] data_in,
    output logic [r2_size-1:0]   cnt,
    output logic                 rdy
);

    typedef enum logic [1:0] {
        S_idle = 2'b00,
        S_1    = 2'b01,
        S_2    = 2'b10,
        S_3    = 2'b11
    } state_e;

    state_e               q_out;
    logic                 load_regs, incr_r2, shift;
    logic                 zero;
    logic [data_size-1:0] r1_q, r1_d;
    logic [r2_size-1:0]   r2_q, r2_d;
    logic                 e_q, e_d;

    assign zero = (r1_q == '0);

`ifdef Q_8_34E_ONEHOT_EN
    // Bit i of onehot_q is set while the controller is in binary state i.
    logic [3:0] onehot_q, onehot_d;

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) onehot_q <= 4'b0001;
        else       onehot_q <= onehot_d;
    end

    always_comb begin
        onehot_d[0] = (onehot_q[0] & ~start) | (onehot_q[3] & ~e_q & zero);
        onehot_d[1] = (onehot_q[0] & start)  | (onehot_q[3] & e_q);
        onehot_d[2] = onehot_q[1]            | (onehot_q[3] & ~e_q & ~zero);
        onehot_d[3] = onehot_q[2];
    end

    assign q_out = state_e'({onehot_q[3] | onehot_q[2], onehot_q[3] | onehot_q[1]});
`else
    state_e state_q, state_d;

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) state_q <= S_idle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_idle:  if (start) state_d = S_1;
            S_1:     state_d = S_2;
            S_2:     state_d = S_3;
            S_3: begin
                if (e_q)       state_d = S_1;
                else if (zero) state_d = S_idle;
                else           state_d = S_2;
            end
            default: state_d = S_idle;
        endcase
    end

    assign q_out = state_q;
`endif

    always_comb begin
        load_regs = 1'b0;
        incr_r2   = 1'b0;
        shift     = 1'b0;
        rdy       = 1'b0;
        case (q_out)
            S_idle: begin
                rdy       = 1'b1;
                load_regs = start;
            end
            S_1:     incr_r2 = 1'b1;
            S_2:     shift   = 1'b1;
            default: ;
        endcase
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        r1_d = r1_q;
        r2_d = r2_q;
        e_d  = e_q;
        if (load_regs) begin
            r1_d = data_in;
            r2_d = '1;
        end
        if (incr_r2) r2_d = r2_q + r2_size'(1);
        if (shift) begin
            e_d  = r1_q[data_size-1];
            r1_d = r1_q << 1;
        end
    end

    // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            r1_q <= '0;
            r2_q <= '0;
            e_q  <= 1'b0;
        end else begin
            r1_q <= r1_d;
            r2_q <= r2_d;
            e_q  <= e_d;
        end
    end

    assign cnt = r2_q;

endmodule

// File: tb/tb_q_8_34e.sv
// Self-checking bench for q_8_34e: counts and latencies against a popcount/latency model.
module tb_q_8_34e;

    logic       clk = 1'b0;
    logic       rst_b = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [3:0] cnt;
    logic       rdy;

    int checks = 0;
    int failures = 0;

    q_8_34e #(.data_size(8), .r2_size(4)) dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .start   (start),
        .data_in (data_in),
        .cnt     (cnt),
        .rdy     (rdy)
    );

    always #5 clk = ~clk;

    function automatic int popcount(input logic [7:0] w);
        int k = 0;
        for (int i = 0; i < 8; i++) if (w[i]) k++;
        return k;
    endfunction

    // Busy cycles: one load/increment lead-in, two cycles per bit shifted until the
    // lowest 1 has left, one extra increment cycle per 1; an empty word takes 3.
    function automatic int exp_latency(input logic [7:0] w);
        int low = 8;
        if (w == 8'h00) return 3;
        for (int i = 7; i >= 0; i--) if (w[i]) low = i;
        return 3 + 2 * (8 - low) + popcount(w);
    endfunction

    task automatic run_count(input logic [7:0] word, input bit scramble, input string name);
        int lat = 0;
        checks++;
        if (rdy !== 1'b1) begin
            failures++;
            $display("FAIL %s idle_before: rdy=%b want 1", name, rdy);
        end
        data_in = word;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (rdy !== 1'b1 && lat < 200) begin
            lat++;
            if (scramble) begin
                data_in = 8'($urandom);
                start   = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (lat !== exp_latency(word)) begin
            failures++;
            $display("FAIL %s latency word=%h: got %0d want %0d", name, word, lat, exp_latency(word));
        end
        checks++;
        if (cnt !== 4'(popcount(word))) begin
            failures++;
            $display("FAIL %s cnt word=%h: got %0d want %0d", name, word, cnt, popcount(word));
        end
    endtask

    task automatic test_reset();
        rst_b   = 1'b1;
        start   = 1'b1;
        data_in = 8'hFF;
        repeat (2) @(negedge clk);
        checks++;
        if (rdy !== 1'b1 || cnt !== 4'd0) begin
            failures++;
            $display("FAIL reset_held: rdy=%b cnt=%0d want rdy=1 cnt=0", rdy, cnt);
        end
        rst_b = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (rdy !== 1'b1 || cnt !== 4'd0) begin
            failures++;
            $display("FAIL reset_release: rdy=%b cnt=%0d want rdy=1 cnt=0", rdy, cnt);
        end
    endtask

    task automatic test_corners();
        run_count(8'h00, 1'b0, "corner00");
        run_count(8'h01, 1'b0, "corner01");
        run_count(8'h80, 1'b0, "corner80");
        run_count(8'hFF, 1'b0, "cornerFF");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) run_count(8'($urandom), 1'b0, "random");
    endtask

    task automatic test_ignore_inputs();
        for (int i = 0; i < 6; i++) run_count(8'($urandom), 1'b1, "ignore");
    endtask

    task automatic test_back_to_back();
        int lat;
        data_in = 8'h00;
        start   = 1'b1;
        for (int w = 0; w < 256; w++) begin
            @(negedge clk);
            lat = 1;
            while (rdy !== 1'b1 && lat < 200) begin
                lat++;
                @(negedge clk);
            end
            // lat includes the single idle cycle in which the next word is loaded
            checks++;
            if (cnt !== 4'(popcount(8'(w))) || lat !== exp_latency(8'(w)) + 1) begin
                failures++;
                $display("FAIL sweep word=%h: cnt=%0d lat=%0d want cnt=%0d lat=%0d",
                         8'(w), cnt, lat, popcount(8'(w)), exp_latency(8'(w)) + 1);
            end
            data_in = 8'(w + 1);
            if (w == 255) start = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midcount();
        data_in = 8'hFF;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        checks++;
        if (rdy !== 1'b1 || cnt !== 4'd0) begin
            failures++;
            $display("FAIL reset_midcount: rdy=%b cnt=%0d want rdy=1 cnt=0", rdy, cnt);
        end
        @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        run_count(8'h0F, 1'b0, "after_reset");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_corners();
        test_random();
        test_ignore_inputs();
        test_back_to_back();
        test_reset_midcount();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
